inst_loader: RTL and testbench
==============================

# inst_loader

Byte-stream program loader for the single-cycle MIPS processor's instruction memory. It accepts a length-prefixed byte stream over a valid/ready handshake and assembles 32-bit words in memory-image byte order. It drives the write port of the instruction RAM that replaces the read-only instruction store. While loading, it holds the CPU in reset.

## Interface
- ADDR_WIDTH, 8, log2 of instruction memory depth in words; the maximum load is 2**ADDR_WIDTH words.
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a load. Sampled only in IDLE, DONE and ERROR; ignored otherwise.
- byte_valid  in  1  byte_in is valid this cycle.
- byte_in  in  8  stream byte.
- byte_ready  out  1  loader accepts byte_in this cycle.
- mem_we  out  1  instruction memory write enable, one-cycle pulse per word.
- mem_addr  out  32  byte address of the write. Always word aligned; bits [1:0] = 0.
- mem_data  out  32  word to write.
- cpu_hold  out  1  CPU reset request.
- busy  out  1  load in progress.
- done  out  1  last load completed successfully. Level signal.
- error  out  1  last load rejected. Level signal.

## Operation
- A byte transfers on a rising edge when byte_valid && byte_ready.
- States and outputs:
  - IDLE: byte_ready=0.
  - LEN_LO: byte_ready=1. The transferred byte becomes count[7:0]. Go to LEN_HI.
  - LEN_HI: byte_ready=1. The transferred byte becomes count[15:8]. Then:
    - count==0: go to DONE.
    - count>2**ADDR_WIDTH: go to ERROR.
    - otherwise: go to DATA.
  - DATA: byte_ready=1. Bytes are shifted into the word register:
    - 1st byte of a word goes to bits [31:24], 2nd to [23:16], 3rd to [15:8], 4th to [7:0].
    - Transfer of the 4th byte loads mem_data and goes to WRITE.
  - WRITE: byte_ready=0, mem_we=1.
    - mem_addr = word_index<<2, where word_index starts at 0 for each load.
    - Next state is DONE if word_index+1==count. Otherwise word_index increments and the state returns to DATA.
  - DONE: done=1, byte_ready=0.
  - ERROR: error=1, byte_ready=0. No memory writes ever occur in a rejected load.
- start in IDLE/DONE/ERROR:
  - clears done, error, word_index and the byte counter;
  - goes to LEN_LO.
- busy=1 and cpu_hold=1 in LEN_LO, LEN_HI, DATA and WRITE; both are 0 elsewhere.
- Bytes presented when byte_ready=0 are not consumed; the source must hold them.
- Byte order: the stream is the memory image in address order. A word read back through the byte-flipping fetch path yields a little-endian instruction, e.g. stream 13 00 08 20 fetches as 0x20080013.
- word_index is ADDR_WIDTH+1 bits wide. count is 16 bits.
- mem_addr[ADDR_WIDTH+1:2] = word_index[ADDR_WIDTH-1:0]. Upper address bits are 0.

## Timing
- Reset values:
  - state IDLE;
  - byte_ready, mem_we, cpu_hold, busy, done and error all 0;
  - mem_addr=0, mem_data=0; internal counters 0.
- start sampled high on edge k: busy, cpu_hold and byte_ready are 1 from cycle k+1.
- Accept of the 4th byte of a word on edge k: mem_we=1 with valid mem_addr/mem_data for exactly cycle k+1, and byte_ready=0 in that cycle.
- Next-byte acceptance is earliest at edge k+2. Peak throughput is 1 word per 5 cycles.
- Final WRITE on cycle k+1: done=1, busy=0 and cpu_hold=0 from cycle k+2.
- mem_addr/mem_data hold their last values outside WRITE.
- LEN_HI accept on edge k with a bad count: error=1 and cpu_hold=0 from cycle k+1.
- Reset mid-load (any state):
  - returns to IDLE the next cycle;
  - the partial word and count are discarded;
  - a pending WRITE is cancelled, so no mem_we in the cycle after reset;
  - memory already written is untouched.
- start held high continuously: a new load begins on each entry to DONE/ERROR only through the next sampled edge in that state. Back-to-back loads are allowed.

## Test plan
- Load of count=2, stream 02 00 13 00 08 20 FF FF FF FF:
  - mem_we pulses twice: addr 0 data 0x13000820, then addr 4 data 0xFFFFFFFF;
  - done=1 two cycles after the final accept;
  - readback via fetch path gives 0x20080013.
- count=0 (stream 00 00): no mem_we, done=1 the cycle after the 2nd byte, cpu_hold=0.
- count=257 with ADDR_WIDTH=8 (01 01): error=1, done=0, no mem_we, byte_ready=0. A following start with count=1 succeeds and clears error.
- Randomised byte_valid gaps for a 4-word load: word content and addresses 0,4,8,12 are identical to the gap-free run, and no byte is dropped or duplicated.
- reset asserted after 2 bytes of word 1 of a 3-word load: all outputs return to reset values. A fresh load then writes from addr 0 with correctly aligned bytes.
- start pulsed in DATA: ignored, load continues, and word_index is not reset.

Source files
------------

// File: rtl/inst_loader.sv
// Byte-stream loader for the instruction RAM: takes a length-prefixed byte stream,
// packs it into 32-bit words in memory-image order and holds the CPU in reset while loading.
module inst_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  state_dbg
);

  // Handshake: a byte moves on a rising edge where byte_valid && byte_ready; while
  // byte_ready is low the source holds byte_in and nothing is consumed.
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERROR
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

  state_t                state, state_next;
  logic [15:0]           count;
  logic [ADDR_WIDTH:0]   word_index;
  logic [1:0]            byte_cnt;
  logic [23:0]           word_reg;
  logic                  xfer;
  logic                  last_word;
  logic [15:0]           len_full;
  logic [31:0]           word_addr;

  assign xfer      = byte_valid && byte_ready;
  assign len_full  = {byte_in, count[7:0]};
  assign last_word = (17'(word_index) + 17'd1) == {1'b0, count};
  assign word_addr = {{(30 - ADDR_WIDTH){1'b0}}, word_index[ADDR_WIDTH-1:0], 2'b00};
  assign cpu_hold  = busy;
  assign state_dbg = state;

  always_comb begin
    state_next = state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) begin
          if (len_full == 16'd0)                 state_next = S_DONE;
          else if ({1'b0, len_full} > MAX_WORDS) state_next = S_ERROR;
          else                                   state_next = S_DATA;
        end
      end
      S_DATA: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid && byte_cnt == 2'd3) state_next = S_WRITE;
      end
      S_WRITE: begin
        mem_we     = 1'b1;
        busy       = 1'b1;
        state_next = last_word ? S_DONE : S_DATA;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_next = S_LEN_LO;
      end
      S_ERROR: begin
        error = 1'b1;
        if (start) state_next = S_LEN_LO;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      count      <= '0;
      word_index <= '0;
      byte_cnt   <= '0;
      word_reg   <= '0;
      mem_addr   <= '0;
      mem_data   <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            count      <= '0;
            word_index <= '0;
            byte_cnt   <= '0;
          end
        end
        S_LEN_LO: if (xfer) count[7:0]  <= byte_in;
        S_LEN_HI: if (xfer) count[15:8] <= byte_in;
        S_DATA: begin
          if (xfer) begin
            byte_cnt <= byte_cnt + 2'd1;
            word_reg <= {word_reg[15:0], byte_in};
            // First byte of the word ends up in bits [31:24].
            if (byte_cnt == 2'd3) begin
              mem_data <= {word_reg, byte_in};
              mem_addr <= word_addr;
            end
          end
        end
        S_WRITE: if (!last_word) word_index <= word_index + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: length-table vectors, hand sequences for the
// multi-cycle corners, and random loads checked against a stream-level write model.
module tb_inst_loader;
  localparam int AW = 8;

  logic        clock = 1'b0;
  logic        reset, start, byte_valid;
  logic [7:0]  byte_in;
  logic        byte_ready, mem_we, cpu_hold, busy, done, error;
  logic [31:0] mem_addr, mem_data;
  logic [2:0]  state_dbg;

  int tests_run = 0;
  int tests_failed = 0;

  logic [63:0] exp_q[$];
  logic [7:0]  stream[$];
  logic [31:0] image[0:255];
  logic [63:0] mon_e;

  typedef struct {
    logic [15:0] count;
    logic        exp_done;
    logic        exp_error;
  } vec_t;

  inst_loader #(.ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .start(start), .byte_valid(byte_valid),
    .byte_in(byte_in), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .error(error), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A load of N words writes stream bytes 2+4i..5+4i, first byte most significant, at 4*i.
  function automatic void model_load(output bit is_err, output int cnt);
    cnt = int'(stream[0]) + 256 * int'(stream[1]);
    is_err = cnt > (1 << AW);
    if (!is_err)
      for (int i = 0; i < cnt; i++)
        exp_q.push_back({32'(i * 4), stream[2+4*i], stream[3+4*i], stream[4+4*i], stream[5+4*i]});
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clock) begin
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {31'd0, mem_we}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", mem_addr, mon_e[63:32]);
        check("write_data", mem_data, mon_e[31:0]);
      end
      image[mem_addr[9:2]] = mem_data;
    end
  end

  // ---------------- drivers ----------------
  // Called just after a falling edge; returns just after the falling edge that follows the transfer.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      byte_valid = 1'b0;
      @(negedge clock);
    end
    byte_valid = 1'b1;
    byte_in    = b;
    n = 0;
    while (!byte_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!byte_ready) check("byte_accept_timeout", {31'd0, byte_ready}, 32'd1);
    @(negedge clock);
  endtask

  task automatic make_stream(input int cnt);
    stream.delete();
    stream.push_back(8'(cnt));
    stream.push_back(8'(cnt >> 8));
    if (cnt <= (1 << AW))
      for (int i = 0; i < 4 * cnt; i++) stream.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic run_load(input int max_gap, input int poke_at, input string tag);
    bit is_err;
    int cnt;
    model_load(is_err, cnt);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check({tag, "_start_busy_hold_ready"}, {29'd0, busy, cpu_hold, byte_ready}, 32'h7);
    for (int i = 0; i < stream.size(); i++) begin
      send_byte(stream[i], $urandom_range(0, max_gap));
      if (i == poke_at) begin
        byte_valid = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check({tag, "_poke_still_busy"}, {30'd0, busy, cpu_hold}, 32'h3);
      end
    end
    byte_valid = 1'b0;
    if (is_err) begin
      check({tag, "_err_e_d_rdy_hold_busy"}, {27'd0, error, done, byte_ready, cpu_hold, busy}, 32'h10);
    end else if (cnt == 0) begin
      check({tag, "_zero_d_e_busy_hold_we"}, {27'd0, done, error, busy, cpu_hold, mem_we}, 32'h10);
    end else begin
      check({tag, "_final_write_we"}, {31'd0, mem_we}, 32'd1);
      @(negedge clock);
      check({tag, "_end_d_e_busy_hold_rdy"}, {27'd0, done, error, busy, cpu_hold, byte_ready}, 32'h10);
    end
    check({tag, "_pending_writes"}, exp_q.size(), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  vec_t        vecs[6];
  logic [31:0] ref_img[4];
  logic [7:0]  saved[$];

  initial begin
    vecs[0] = '{16'd0,      1'b1, 1'b0};
    vecs[1] = '{16'd1,      1'b1, 1'b0};
    vecs[2] = '{16'd3,      1'b1, 1'b0};
    vecs[3] = '{16'd256,    1'b1, 1'b0};
    vecs[4] = '{16'd257,    1'b0, 1'b1};
    vecs[5] = '{16'hFFFF,   1'b0, 1'b1};

    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (2) @(negedge clock);
    check("reset_outputs", {26'd0, byte_ready, mem_we, cpu_hold, busy, done, error}, 32'd0);
    check("reset_addr", mem_addr, 32'd0);
    check("reset_data", mem_data, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_outputs", {26'd0, byte_ready, mem_we, cpu_hold, busy, done, error}, 32'd0);

    // Worked example: two words, fetch path flips bytes.
    stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h08, 8'h20, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_load(0, -1, "plan");
    check("plan_word0", image[0], 32'h13000820);
    check("plan_word1", image[1], 32'hFFFFFFFF);
    check("plan_fetch", {image[0][7:0], image[0][15:8], image[0][23:16], image[0][31:24]}, 32'h20080013);

    // Length table.
    foreach (vecs[v]) begin
      make_stream(int'(vecs[v].count));
      run_load(2, -1, "vec");
      check("vec_done", {31'd0, done}, {31'd0, vecs[v].exp_done});
      check("vec_error", {31'd0, error}, {31'd0, vecs[v].exp_error});
    end

    // Rejected load followed by a good one.
    make_stream(257);
    run_load(0, -1, "err");
    make_stream(1);
    run_load(0, -1, "recover");
    check("recover_error_cleared", {30'd0, error, done}, 32'h1);

    // Same 4-word image with and without byte_valid gaps.
    make_stream(4);
    saved = stream;
    run_load(0, -1, "nogap");
    for (int i = 0; i < 4; i++) ref_img[i] = image[i];
    for (int i = 0; i < 4; i++) image[i] = 32'h0;
    stream = saved;
    run_load(5, -1, "gap");
    for (int i = 0; i < 4; i++) check("gap_vs_nogap", image[i], ref_img[i]);

    // Reset two bytes into word 1 of a 3-word load: only word 0 lands.
    make_stream(3);
    exp_q.push_back({32'd0, stream[2], stream[3], stream[4], stream[5]});
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(stream[i], 0);
    byte_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("midreset_outputs", {26'd0, byte_ready, mem_we, cpu_hold, busy, done, error}, 32'd0);
    check("midreset_addr", mem_addr, 32'd0);
    check("midreset_data", mem_data, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("midreset_idle_we", {31'd0, mem_we}, 32'd0);
    check("midreset_written", exp_q.size(), 32'd0);
    make_stream(3);
    run_load(1, -1, "after_reset");

    // start pulsed in the middle of word 1 must be ignored.
    make_stream(3);
    run_load(0, 7, "poke");

    // Random loads.
    for (int r = 0; r < 6; r++) begin
      make_stream($urandom_range(1, 8));
      run_load($urandom_range(0, 3), -1, "rand");
    end

    repeat (3) @(negedge clock);
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
